// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences PLL reset, lock qualification and release of PLL-domain reset.
// Optional build macro PLL_LOCK_DEBOUNCE_EN: in RUN, lock loss needs 4 consecutive low cycles of the synced lock.
module pll_lock_supervisor #(
  parameter int unsigned CNT_W            = 16,
  parameter int unsigned PLL_RST_CYC      = 16,
  parameter int unsigned LOCK_TIMEOUT_CYC = 50000,
  parameter int unsigned LOCK_STABLE_CYC  = 1024
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       relock_req,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic [1:0] state,
  output logic [7:0] relock_count,
  output logic       timeout_err
);

  localparam logic [1:0] S_PLLRST   = 2'd0;
  localparam logic [1:0] S_WAITLOCK = 2'd1;
  localparam logic [1:0] S_STABLE   = 2'd2;
  localparam logic [1:0] S_RUN      = 2'd3;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);

  logic             lk_m;
  logic             lk_s;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       state_n;
  logic [7:0]       relock_count_n;
  logic             timeout_err_n;
  logic             bump;
  logic             lock_loss_c;

`ifdef PLL_LOCK_DEBOUNCE_EN
  // Counts consecutive low cycles of lk_s while running; the fourth one is a loss.
  logic [1:0] dbc;
  logic [1:0] dbc_n;

  always_comb begin
    dbc_n       = 2'd0;
    lock_loss_c = 1'b0;
    if (state == S_RUN && !lk_s) begin
      if (dbc == 2'd3) lock_loss_c = 1'b1;
      else             dbc_n       = dbc + 2'd1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) dbc <= 2'd0;
    else     dbc <= dbc_n;
  end
`else
  assign lock_loss_c = (state == S_RUN) && !lk_s;
`endif

  // Next-state, shared counter and status update.
  always_comb begin
    state_n        = state;
    cnt_n          = cnt + CNT_W'(1);
    relock_count_n = relock_count;
    timeout_err_n  = timeout_err;
    bump           = 1'b0;
    case (state)
      S_PLLRST: begin
        if (cnt == RST_LAST) state_n = S_WAITLOCK;
      end
      S_WAITLOCK: begin
        if (relock_req) state_n = S_PLLRST;
        else if (lk_s) state_n = S_STABLE;
        else if (cnt == TIMEOUT_LAST) begin
          state_n       = S_PLLRST;
          timeout_err_n = 1'b1;
          bump          = 1'b1;
        end
      end
      S_STABLE: begin
        if (relock_req) state_n = S_PLLRST;
        else if (!lk_s) state_n = S_WAITLOCK;
        else if (cnt == STABLE_LAST) state_n = S_RUN;
      end
      default: begin
        // RUN: counter idles; a loss and a request together still count once.
        cnt_n = cnt;
        if (lock_loss_c) begin
          state_n = S_PLLRST;
          bump    = 1'b1;
        end else if (relock_req) begin
          state_n = S_PLLRST;
        end
      end
    endcase
    if (bump && relock_count != 8'hFF) relock_count_n = relock_count + 8'd1;
    if (state_n != state) cnt_n = '0;
  end

  // Registers; pll_rst/sys_rst are decoded from the next state so they align with state.
  always_ff @(posedge refclk) begin
    if (rst) begin
      lk_m         <= 1'b0;
      lk_s         <= 1'b0;
      state        <= S_PLLRST;
      cnt          <= '0;
      pll_rst      <= 1'b1;
      sys_rst      <= 1'b1;
      relock_count <= 8'd0;
      timeout_err  <= 1'b0;
    end else begin
      lk_m         <= pll_locked;
      lk_s         <= lk_m;
      state        <= state_n;
      cnt          <= cnt_n;
      pll_rst      <= (state_n == S_PLLRST);
      sys_rst      <= (state_n != S_RUN);
      relock_count <= relock_count_n;
      timeout_err  <= timeout_err_n;
    end
  end

endmodule
